// File: rtl/hamming74_serial_dec_ctrl.sv
// Sequencing controller for a bit-serial (7,4) cyclic Hamming decoder, g(x)=x^3+x+1.
// Divides the received word into a syndrome, then runs a Meggitt correction pass MSB first.
module hamming74_serial_dec_ctrl #(
   parameter bit CORR_EN = 1'b1,
   parameter int STATS_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [6:0]         y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [6:0]         c,
   output logic               err,
   output logic [2:0]         err_pos,
   output logic [STATS_W-1:0] err_cnt,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYN  = 2'd1,
      CORR = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [6:0]         wbuf_q, wbuf_d;
   logic [2:0]         s_q, s_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [6:0]         c_q, c_d;
   logic               err_q, err_d;
   logic [2:0]         err_pos_q, err_pos_d;
   logic [STATS_W-1:0] err_cnt_q, err_cnt_d;

   logic               fb_s;
   logic               e_s;
   logic [2:0]         syn_shift_s;
   logic [2:0]         corr_shift_s;

   // Divider step with the current buffer bit as input, and the zero-input Meggitt step.
   // 3'b101 is x^6 mod g: the syndrome of an error in the bit now at the output position.
   always_comb begin
      fb_s         = s_q[2];
      syn_shift_s  = {s_q[1], s_q[0] ^ fb_s, wbuf_q[cnt_q] ^ fb_s};
      corr_shift_s = {s_q[1], s_q[0] ^ fb_s, fb_s};
      e_s          = (s_q == 3'b101);
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      wbuf_d    = wbuf_q;
      s_d       = s_q;
      cnt_d     = cnt_q;
      c_d       = c_q;
      err_d     = err_q;
      err_pos_d = err_pos_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               wbuf_d    = y;
               s_d       = 3'd0;
               cnt_d     = 3'd6;
               err_d     = 1'b0;
               err_pos_d = 3'd7;
               state_d   = SYN;
            end else begin
               state_d = IDLE;
            end
         end
         SYN: begin
            s_d = syn_shift_s;
            if (cnt_q == 3'd0) begin
               err_d   = (syn_shift_s != 3'd0);
               cnt_d   = 3'd6;
               state_d = CORR;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         CORR: begin
            c_d[cnt_q] = wbuf_q[cnt_q] ^ (e_s & CORR_EN);
            if (e_s) begin
               s_d       = 3'd0;
               err_pos_d = cnt_q;
            end else begin
               s_d = corr_shift_s;
            end
            if (cnt_q == 3'd0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               if (err_q && (err_cnt_q != {STATS_W{1'b1}})) begin
                  err_cnt_d = err_cnt_q + STATS_W'(1);
               end else begin
                  err_cnt_d = err_cnt_q;
               end
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wbuf_q    <= 7'd0;
         s_q       <= 3'd0;
         cnt_q     <= 3'd0;
         c_q       <= 7'd0;
         err_q     <= 1'b0;
         err_pos_q <= 3'd7;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         wbuf_q    <= wbuf_d;
         s_q       <= s_d;
         cnt_q     <= cnt_d;
         c_q       <= c_d;
         err_q     <= err_d;
         err_pos_q <= err_pos_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == SYN) || (state_q == CORR);
   assign c         = c_q;
   assign err       = err_q;
   assign err_pos   = err_pos_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hamming74_serial_dec_ctrl.sv
// Scoreboard bench: a correcting 8-bit-counter instance and a detect-only 2-bit-counter
// instance decode the same words; each has its own expectation queue and monitor.
module tb_hamming74_serial_dec_ctrl;

   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready;
   logic [6:0] y;

   logic       a_in_ready, a_out_valid, a_err, a_busy;
   logic [6:0] a_c;
   logic [2:0] a_err_pos;
   logic [7:0] a_err_cnt;

   logic       b_in_ready, b_out_valid, b_err, b_busy;
   logic [6:0] b_c;
   logic [2:0] b_err_pos;
   logic [1:0] b_err_cnt;

   typedef struct packed {
      logic [6:0] c;
      logic       err;
      logic [2:0] pos;
   } exp_t;

   exp_t       qa[$], qb[$];
   exp_t       ea, eb;
   logic [7:0] exp_cnt_a;
   logic [1:0] exp_cnt_b;
   int         n_chk = 0;
   int         n_pass = 0;

   hamming74_serial_dec_ctrl #(.CORR_EN(1'b1), .STATS_W(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .y(y),
      .out_valid(a_out_valid), .out_ready(out_ready), .c(a_c), .err(a_err),
      .err_pos(a_err_pos), .err_cnt(a_err_cnt), .busy(a_busy)
   );

   hamming74_serial_dec_ctrl #(.CORR_EN(1'b0), .STATS_W(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .y(y),
      .out_valid(b_out_valid), .out_ready(out_ready), .c(b_c), .err(b_err),
      .err_pos(b_err_pos), .err_cnt(b_err_cnt), .busy(b_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Monitor for the correcting instance
   always @(negedge clk) begin
      if (!rst && a_out_valid && out_ready) begin
         if (qa.size() == 0) begin
            n_chk++;
            $display("FAIL a_unexpected_output: got c=%h with no expectation queued", a_c);
         end else begin
            ea = qa.pop_front();
            chk("a_c", a_c, ea.c);
            chk("a_err", a_err, ea.err);
            chk("a_err_pos", a_err_pos, ea.pos);
            chk("a_err_cnt", a_err_cnt, exp_cnt_a);
            if (ea.err && exp_cnt_a != 8'hFF) exp_cnt_a = exp_cnt_a + 8'd1;
         end
      end
   end

   // Monitor for the detect-only instance
   always @(negedge clk) begin
      if (!rst && b_out_valid && out_ready) begin
         if (qb.size() == 0) begin
            n_chk++;
            $display("FAIL b_unexpected_output: got c=%h with no expectation queued", b_c);
         end else begin
            eb = qb.pop_front();
            chk("b_c", b_c, eb.c);
            chk("b_err", b_err, eb.err);
            chk("b_err_pos", b_err_pos, eb.pos);
            chk("b_err_cnt", b_err_cnt, exp_cnt_b);
            if (eb.err && exp_cnt_b != 2'b11) exp_cnt_b = exp_cnt_b + 2'd1;
         end
      end
   end

   // Offers word w until accepted; the detect-only instance must return w unmodified.
   task automatic send(input logic [6:0] w, input logic [6:0] ec, input logic ee,
                       input logic [2:0] ep, input bit push);
      int n = 0;
      y = w;
      in_valid = 1'b1;
      while (!a_in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) chk("accept_timeout", n, 0);
      if (push) begin
         qa.push_back({ec, ee, ep});
         qb.push_back({w, ee, ep});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk("drain_timeout", n, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [6:0] one;
      int n;
      one = 7'd1;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; y = 7'd0;
      exp_cnt_a = 8'd0; exp_cnt_b = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_c", a_c, 0);
      chk("rst_err", a_err, 0);
      chk("rst_err_pos", a_err_pos, 7);
      chk("rst_err_cnt", a_err_cnt, 0);
      chk("rst_busy", a_busy, 0);
      rst = 1'b0;

      // valid codeword; out_valid after 15 edges counting the accept edge
      send(7'h0B, 7'h0B, 1'b0, 3'd7, 1'b1);
      n = 1;
      chk("busy_in_syn", a_busy, 1);
      while (!a_out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, 15);
      wait_done();

      send(7'h4B, 7'h0B, 1'b1, 3'd6, 1'b1);
      send(7'h0A, 7'h0B, 1'b1, 3'd0, 1'b1);
      for (int i = 0; i < 7; i++) send(7'h0B ^ (one << i), 7'h0B, 1'b1, 3'(i), 1'b1);
      for (int i = 0; i < 7; i++) send(one << i, 7'h00, 1'b1, 3'(i), 1'b1);
      wait_done();
      chk("a_cnt_after_sweep", a_err_cnt, 16);
      chk("b_cnt_saturated", b_err_cnt, 3);

      // consumer stall: output held, a waiting word must not be taken
      out_ready = 1'b0;
      send(7'h0B, 7'h0B, 1'b0, 3'd7, 1'b1);
      n = 0;
      while (!a_out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      y = 7'h4B;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("stall_out_valid", a_out_valid, 1);
         chk("stall_in_ready", a_in_ready, 0);
         chk("stall_c", a_c, 7'h0B);
         chk("stall_err_pos", a_err_pos, 7);
      end
      out_ready = 1'b1;
      send(7'h4B, 7'h0B, 1'b1, 3'd6, 1'b1);
      wait_done();

      // reset in the middle of the correction pass
      send(7'h4B, 7'h0B, 1'b1, 3'd6, 1'b0);
      repeat (10) begin
         @(posedge clk); #1;
      end
      chk("busy_in_corr", a_busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_cnt_a = 8'd0;
      exp_cnt_b = 2'd0;
      chk("abort_in_ready", a_in_ready, 1);
      chk("abort_out_valid", a_out_valid, 0);
      chk("abort_busy", a_busy, 0);
      chk("abort_err_cnt", a_err_cnt, 0);
      chk("abort_b_err_cnt", b_err_cnt, 0);
      chk("abort_err_pos", a_err_pos, 7);
      send(7'h4B, 7'h0B, 1'b1, 3'd6, 1'b1);
      wait_done();
      chk("post_abort_cnt", a_err_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/hamming74_serial_dec_ctrl.md
Name: hamming74_serial_dec_ctrl

Overview:
- Sequencing controller for the bit-serial (7,4) cyclic Hamming decoder, generator g(x)=x^3+x+1.
- Accepts one 7-bit received word over a valid/ready handshake, then runs the 3-bit syndrome divider for 7 shift cycles and the Meggitt correction pass for 7 cycles.
- Presents the corrected word with error flags over a valid/ready output handshake.
- Sits between the channel word buffer and downstream consumers; keeps a saturating count of corrected words.

Parameters:
- CORR_EN, 1, 1 = flip the detected bit; 0 = detect only (word passes unmodified, flags still reported).
- STATS_W, 8, width of the saturating corrected-word counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  received word available
- in_ready  out  1  controller can accept a word
- y  in  7  received word; y[6] is the highest-order term
- out_valid  out  1  decoded result available
- out_ready  in  1  consumer accepts the result
- c  out  7  decoded word; c[6] is the highest-order term
- err  out  1  nonzero syndrome detected
- err_pos  out  3  bit index corrected (0..6); 7 = no error
- err_cnt  out  STATS_W  saturating count of words with err=1
- busy  out  1  high in SYN or CORR

Behaviour:
- Reset (rst=1 at an edge) forces the following, from any state, aborting any word in flight:
  - state=IDLE, in_ready=1, out_valid=0, c=0, err=0, err_pos=7, err_cnt=0, busy=0.
  - Syndrome register cleared; bit counter cleared.
- States: IDLE -> SYN -> CORR -> DONE -> IDLE.
- IDLE:
  - in_ready=1 (the only state with in_ready=1).
  - On in_valid&in_ready: latch y into buf; s={s2,s1,s0}=0; cnt=6; go to SYN.
- SYN (7 cycles, cnt 6..0), each cycle:
  - fb=s2; s2<=s1; s1<=s0^fb; s0<=buf[cnt]^fb.
  - At cnt=0: set err=(next s != 0); reset cnt=6; go to CORR.
- CORR (7 cycles, cnt 6..0), each cycle:
  - e=(s==3'b101), the pattern for x^6 mod g.
  - Corrected bit c[cnt]=buf[cnt]^(e&CORR_EN).
  - Shift with zero input: fb=s2; s2<=s1; s1<=s0^fb; s0<=fb.
  - If e: s<=0 and err_pos<=cnt, overriding the shift.
  - At cnt=0: go to DONE.
- DONE:
  - out_valid=1; c, err and err_pos are held stable until out_ready=1.
  - On out_valid&out_ready: go to IDLE; err_cnt<=err_cnt+err, saturating at all-ones.
- Latency: out_valid is high after 15 rising edges following the accepting edge. Minimum initiation interval is 16 cycles (accept edge + 14 work edges + 1 output cycle with out_ready=1).
- out_ready held low: controller stays in DONE indefinitely; in_ready stays 0; no input is lost or overwritten.
- in_valid while not in IDLE is ignored; the source must hold the word until in_ready.
- The code is perfect, so every nonzero syndrome maps to exactly one bit position: err=1 implies err_pos != 7. Double errors are miscorrected silently, by design.
- err_pos/err/c update only while a word is processed; they are undefined-free (registered) at all times.
- busy=1 exactly in SYN and CORR.
- c is combinationally stable during DONE; out_valid never drops without a completed handshake except on rst.

Test Plan:
- y=7'h0B (valid codeword), out_ready=1 -> c=7'h0B, err=0, err_pos=7, out_valid on edge 15, err_cnt=0.
- y=7'h4B (bit 6 flipped) -> c=7'h0B, err=1, err_pos=6, err_cnt=1.
- y=7'h0A (bit 0 flipped) -> c=7'h0B, err=1, err_pos=0. Then sweep every single-bit flip of 7'h0B and 7'h00 -> always corrected, err_pos equals the flipped index.
- out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0, second in_valid word not accepted until after the handshake.
- rst asserted during the CORR phase -> next cycle IDLE, out_valid=0, err_cnt=0. A fresh 7'h4B then decodes normally.
- STATS_W=2, CORR_EN=0: five erroneous words -> err_cnt saturates at 3; c equals the received y unmodified; err_pos is still reported.
